// File: rtl/branch_resolve_predict_if.sv
// Bundle of the resolve request, fetch-side lookup and registered result /
// statistics signals for branch_resolve_predict.
//   master: drives the request (in_valid, branch, op_a, op_b, pc, pred_taken,
//           stall) and lookup_pc; observes lookup_taken, res_*, counts.
//   slave : the resolver/predictor itself.
interface branch_resolve_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [3:0]       branch;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [31:0]      pc;
  logic             pred_taken;
  logic             stall;
  logic [31:0]      lookup_pc;
  logic             lookup_taken;
  logic             res_valid;
  logic             res_taken;
  logic             res_link;
  logic             res_mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output in_valid, branch, op_a, op_b, pc, pred_taken, stall, lookup_pc,
    input  lookup_taken, res_valid, res_taken, res_link, res_mispredict,
           branch_count, mispredict_count
  );
  modport slave (
    input  in_valid, branch, op_a, op_b, pc, pred_taken, stall, lookup_pc,
    output lookup_taken, res_valid, res_taken, res_link, res_mispredict,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_predict.sv
// Branch resolver with a bimodal (2-bit saturating counter) predictor.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - branch_resolve_predict_if.slave: request in, lookup, registered
//          one-cycle result, saturating branch/mispredict statistics.
// A request is accepted when in_valid & ~stall; its result appears on the
// next edge. stall freezes the result stage and blocks all state updates.
module branch_resolve_predict #(
  parameter int XLEN      = 32,
  parameter int PHT_DEPTH = 16,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
  input logic clk,
  input logic rst,
  branch_resolve_predict_if.slave bus
);
  localparam logic [3:0] BEQ = 4'd0, BNE = 4'd1, BGEZ = 4'd2, BGTZ = 4'd3,
                         BLEZ = 4'd4, BLTZ = 4'd5, BGEZAL = 4'd6, BLTZAL = 4'd7;

  logic [1:0]       pht [PHT_DEPTH];
  logic             accept, is_br, taken, sign_a, zero_a, link;
  logic [IDX_W-1:0] upd_idx, lk_idx;

  assign sign_a  = bus.op_a[XLEN-1];
  assign zero_a  = (bus.op_a == '0);
  assign accept  = bus.in_valid & ~bus.stall;
  // Codes 1000-1111 are not branches: only the low eight codes are real.
  assign is_br   = ~bus.branch[3];
  assign link    = (bus.branch == BGEZAL) || (bus.branch == BLTZAL);
  assign upd_idx = bus.pc[IDX_W+1:2];
  assign lk_idx  = bus.lookup_pc[IDX_W+1:2];

  always_comb begin
    taken = 1'b0;
    case (bus.branch)
      BEQ:            taken = (bus.op_a == bus.op_b);
      BNE:            taken = (bus.op_a != bus.op_b);
      BGEZ, BGEZAL:   taken = ~sign_a;
      BGTZ:           taken = ~sign_a & ~zero_a;
      BLEZ:           taken = sign_a | zero_a;
      BLTZ, BLTZAL:   taken = sign_a;
      default:        taken = 1'b0;
    endcase
  end

  // Reads registered table only, so an update in this cycle is not seen.
  assign bus.lookup_taken = pht[lk_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_link       <= 1'b0;
      bus.res_mispredict <= 1'b0;
    end else if (!bus.stall) begin
      bus.res_valid      <= bus.in_valid;
      bus.res_taken      <= bus.in_valid & taken;
      bus.res_link       <= bus.in_valid & link;
      bus.res_mispredict <= bus.in_valid & is_br & (taken != bus.pred_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
    end else if (accept && is_br) begin
      if (taken && pht[upd_idx] != 2'b11)       pht[upd_idx] <= pht[upd_idx] + 2'b01;
      else if (!taken && pht[upd_idx] != 2'b00) pht[upd_idx] <= pht[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.branch_count     <= '0;
      bus.mispredict_count <= '0;
    end else if (accept && is_br) begin
      if (bus.branch_count != '1) bus.branch_count <= bus.branch_count + 1'b1;
      if (taken != bus.pred_taken && bus.mispredict_count != '1)
        bus.mispredict_count <= bus.mispredict_count + 1'b1;
    end
  end

  // Address bits outside the table index do not affect prediction.
  logic unused_bits;
  assign unused_bits = ^{bus.pc[31:IDX_W+2], bus.pc[1:0],
                         bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0]};
endmodule

// File: tb/tb_branch_resolve_predict.sv
module tb_branch_resolve_predict;
  localparam int XLEN = 32, DEPTH = 16, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_predict_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  branch_resolve_predict #(.XLEN(XLEN), .PHT_DEPTH(DEPTH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit v, t, l, m;
    int bc, mc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   pht_m [DEPTH];
  int   bc_m, mc_m;
  int   vectors = 0, miscompares = 0;

  function automatic void chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference rules: signed compares on the operands as plain integers.
  function automatic bit outcome(input logic [3:0] br, input logic [31:0] a, b);
    int sa;
    sa = $signed(a);
    case (br)
      4'd0:       return a == b;
      4'd1:       return a != b;
      4'd2, 4'd6: return sa >= 0;
      4'd3:       return sa > 0;
      4'd4:       return sa <= 0;
      4'd5, 4'd7: return sa < 0;
      default:    return 0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] p);
    return (p >> 2) % DEPTH;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) pht_m[i] = 1;
    bc_m = 0; mc_m = 0;
  endfunction

  // Issue one cycle of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input bit v, input logic [3:0] br, input logic [31:0] a, b, p,
                      input bit pt, st, input logic [31:0] lpc);
    exp_t e;
    bit   tk, real_br;
    bus.in_valid = v; bus.branch = br; bus.op_a = a; bus.op_b = b; bus.pc = p;
    bus.pred_taken = pt; bus.stall = st; bus.lookup_pc = lpc;
    #1;
    chk("lookup_taken", bus.lookup_taken, pht_m[idx_of(lpc)] >= 2);
    if (v && !st) begin
      tk = outcome(br, a, b);
      real_br = (br < 8);
      if (real_br) begin
        pht_m[idx_of(p)] = tk ? ((pht_m[idx_of(p)] < 3) ? pht_m[idx_of(p)] + 1 : 3)
                              : ((pht_m[idx_of(p)] > 0) ? pht_m[idx_of(p)] - 1 : 0);
        if (bc_m < CMAX) bc_m++;
        if (tk != pt && mc_m < CMAX) mc_m++;
      end
      e.v = 1; e.t = tk; e.l = (br == 4'd6 || br == 4'd7);
      e.m = real_br && (tk != pt); e.bc = bc_m; e.mc = mc_m;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(0, 4'd8, 0, 0, 0, 0, 0, lpc);
  endtask

  task automatic do_reset();
    rst = 1'b1; q.delete(); model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: classifies each edge from the request inputs and compares outputs.
  initial begin
    exp_t e;
    bit acc, stl, rs;
    last = '{0, 0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      acc = bus.in_valid & ~bus.stall & ~rst;
      stl = bus.stall; rs = rst;
      #2;
      if (rs) begin
        last = '{0, 0, 0, 0, 0, 0};
      end else if (acc) begin
        if (q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          last = q.pop_front();
        end
      end else if (!stl) begin
        last.v = 0; last.t = 0; last.l = 0; last.m = 0;
      end
      e = last;
      chk("res_valid", bus.res_valid, e.v);
      chk("res_taken", bus.res_taken, e.t);
      chk("res_link", bus.res_link, e.l);
      chk("res_mispredict", bus.res_mispredict, e.m);
      chk("branch_count", bus.branch_count, e.bc);
      chk("mispredict_count", bus.mispredict_count, e.mc);
    end
  end

  initial begin
    logic [31:0] a, b, p;
    bus.in_valid = 0; bus.branch = 4'd8; bus.op_a = 0; bus.op_b = 0; bus.pc = 0;
    bus.pred_taken = 0; bus.stall = 0; bus.lookup_pc = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_res_valid", bus.res_valid, 0);
    chk("reset_branch_count", bus.branch_count, 0);

    // Signed compare corners.
    step(1, 4'd5, 32'h8000_0000, 0, 32'h10, 1, 0, 32'h10);
    step(1, 4'd3, 32'h8000_0000, 0, 32'h10, 1, 0, 32'h10);
    step(1, 4'd2, 32'h0, 0, 32'h14, 0, 0, 32'h14);
    step(1, 4'd4, 32'h0, 0, 32'h14, 0, 0, 32'h14);
    step(1, 4'd3, 32'h7fff_ffff, 0, 32'h14, 1, 0, 32'h14);
    idle(32'h10);

    // Training at 0x40 with aliasing partner 0x80 observed on lookup.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 4'd0, 32'h5, 32'h5, 32'h40, 1, 0, 32'h40);
    idle(32'h40);
    idle(32'h80);
    chk("alias_lookup_0x80", bus.lookup_taken, 1);
    step(1, 4'd1, 32'h5, 32'h5, 32'h80, 1, 0, 32'h80);
    step(1, 4'd1, 32'h5, 32'h5, 32'h80, 1, 0, 32'h40);
    idle(32'h40);

    // Stall hold after an accepted taken BNE.
    step(1, 4'd1, 32'h1, 32'h2, 32'h24, 0, 0, 32'h24);
    for (int i = 0; i < 3; i++)
      step(1, 4'd0, $urandom, $urandom, 32'h24, 1, 1, 32'h24);
    idle(32'h24);

    // Mispredicted link branch, then a non-branch.
    step(1, 4'd7, 32'hffff_ffff, 0, 32'h30, 0, 0, 32'h30);
    step(1, 4'd8, 32'h0, 0, 32'h30, 1, 0, 32'h30);
    step(1, 4'd12, 32'h0, 0, 32'h30, 1, 0, 32'h30);

    // Reset between an accept and its capture edge.
    bus.in_valid = 1; bus.branch = 4'd0; bus.op_a = 0; bus.op_b = 0;
    bus.pc = 32'h40; bus.pred_taken = 0; bus.stall = 0;
    #3;
    rst = 1'b1; q.delete(); model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) idle(i * 4);

    // Randomized traffic; narrow counters reach saturation.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = 0; b = $urandom; end
        1: begin a = 32'h8000_0000; b = $urandom; end
        2: begin a = $urandom; b = a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      p = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      step($urandom_range(0, 3) != 0, 4'($urandom), a, b, p,
           1'($urandom), $urandom_range(0, 4) == 0,
           {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00});
    end
    idle(0);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
